// File: rtl/ntt_pkg.sv
// Shared NTT definitions: default frame geometry, loader FSM states and the
// bit-reversal helper used to scatter samples into butterfly order.
package ntt_pkg;

    localparam int unsigned N_DEF  = 17;
    localparam int unsigned D_DEF  = 8;
    localparam int unsigned Q_DEF  = 65537;
    localparam int unsigned STAGES = $clog2(D_DEF);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } loader_state_t;

    // Reverses the low 'bits' bits of v; upper bits of the result are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned bits);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < bits; i++) begin
            r[i] = v[bits-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_q_reduce.sv
// Single conditional subtraction bringing an N-bit value into [0, Q-1];
// valid because every N-bit input is below 2*Q.
module mod_q_reduce #(
    parameter int unsigned N = 17,
    parameter int unsigned Q = 65537
) (
    input  logic [N-1:0] x,
    output logic [N-1:0] r
);

    localparam logic [N-1:0] QV = N'(Q);

    always_comb begin
        r = (x >= QV) ? (x - QV) : x;
    end

endmodule

// File: rtl/ntt_coeff_loader.sv
// Collects D reduced coefficients into a flat frame (optionally in bit-reversed
// slot order), then pulses start and holds busy while the transform consumes it.
module ntt_coeff_loader
    import ntt_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned D      = D_DEF,
    parameter int unsigned Q      = Q_DEF,
    parameter int unsigned BITREV = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    input  logic [N-1:0]   in_data,
    output logic           in_ready,
    output logic           start,
    output logic           busy,
    output logic [D*N-1:0] a
);

    localparam int unsigned S  = $clog2(D);
    localparam int unsigned RW = $clog2(S + 2);

    loader_state_t state;
    logic [S-1:0]  cnt;
    logic [RW-1:0] rcnt;
    logic [N-1:0]  red;
    logic [S-1:0]  slot;
    logic          write_en;
    logic [N-1:0]  frame [D];

    mod_q_reduce #(.N(N), .Q(Q)) u_reduce (
        .x (in_data),
        .r (red)
    );

    assign in_ready = (state == FILL);
    // Flush takes priority over a sample presented in the same cycle.
    assign write_en = in_ready && in_valid && !flush;
    assign slot     = (BITREV != 0) ? S'(bitrev(32'(cnt), S)) : cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
            cnt   <= '0;
            rcnt  <= '0;
            start <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    start <= 1'b0;
                    busy  <= 1'b0;
                    if (flush) begin
                        cnt <= '0;
                    end else if (in_valid) begin
                        cnt <= cnt + S'(1);
                        if (cnt == S'(D - 1)) begin
                            state <= LAUNCH;
                            start <= 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    start <= 1'b0;
                    busy  <= 1'b1;
                    rcnt  <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (rcnt == RW'(S)) begin
                        busy  <= 1'b0;
                        state <= FILL;
                    end else begin
                        rcnt <= rcnt + RW'(1);
                    end
                end
                default: begin
                    state <= FILL;
                    start <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < D; k++) begin
                frame[k] <= '0;
            end
        end else if (write_en) begin
            frame[slot] <= red;
        end
    end

    for (genvar k = 0; k < D; k++) begin : g_flat
        assign a[N*k +: N] = frame[k];
    end

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// Scoreboard bench: a bit-reversed and a natural-order loader share stimulus;
// a behavioural model queues expected frames, a monitor checks them at start.
module tb_ntt_coeff_loader;

    localparam int unsigned N = 17;
    localparam int unsigned D = 8;
    localparam int unsigned Q = 65537;
    localparam int unsigned S = 3;
    localparam int unsigned W = D * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic [N-1:0] in_data = '0;
    logic ready_r, start_r, busy_r, ready_n, start_n, busy_n;
    logic [W-1:0] a_r, a_n;

    ntt_coeff_loader #(.N(N), .D(D), .Q(Q), .BITREV(1)) dut_rev (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready_r), .start(start_r), .busy(busy_r), .a(a_r)
    );

    ntt_coeff_loader #(.N(N), .D(D), .Q(Q), .BITREV(0)) dut_nat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready_n), .start(start_n), .busy(busy_n), .a(a_n)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: plain arrays indexed by sample number.
    int unsigned m_cnt = 0;
    int          m_block = 0;
    logic [N-1:0] m_nat [D];
    logic [N-1:0] m_rev [D];
    logic [W-1:0] q_nat [$];
    logic [W-1:0] q_rev [$];
    int frames_pushed = 0;
    int starts_seen = 0;

    function automatic int unsigned rev_idx(input int unsigned c);
        int unsigned r = 0;
        for (int i = 0; i < S; i++)
            if (((c >> i) & 1) != 0) r += 1 << (S - 1 - i);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < D; k++) begin
            m_nat[k] = '0;
            m_rev[k] = '0;
        end
        m_cnt = 0;
        m_block = 0;
        q_nat.delete();
        q_rev.delete();
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic cycle(input logic v, input logic f, input logic [N-1:0] d);
        logic ready_m;
        int unsigned x;
        logic [W-1:0] fn, fr;
        ready_m = (m_block == 0);
        chk("in_ready_rev", W'(ready_r), W'(ready_m));
        chk("in_ready_nat", W'(ready_n), W'(ready_m));
        in_valid = v;
        flush = f;
        in_data = d;
        if (!ready_m) begin
            m_block--;
        end else if (f) begin
            m_cnt = 0;
        end else if (v) begin
            x = d;
            if (x >= Q) x = x - Q;
            m_nat[m_cnt] = N'(x);
            m_rev[rev_idx(m_cnt)] = N'(x);
            m_cnt++;
            if (m_cnt == D) begin
                for (int k = 0; k < D; k++) begin
                    fn[k*N +: N] = m_nat[k];
                    fr[k*N +: N] = m_rev[k];
                end
                q_nat.push_back(fn);
                q_rev.push_back(fr);
                frames_pushed++;
                m_cnt = 0;
                m_block = S + 2;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
    endtask

    // Monitor: frame check on start, then busy length and frame stability.
    int exp_busy = 0;
    logic [W-1:0] snap_r, snap_n;
    always @(negedge clk) begin
        if (rst) begin
            exp_busy = 0;
        end else if (start_r || start_n) begin
            starts_seen++;
            chk("start_nat", W'(start_n), W'(1));
            chk("start_rev", W'(start_r), W'(1));
            chk("busy_at_start", W'(busy_r | busy_n), W'(0));
            if (q_rev.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_start: got start=1 want no pending frame");
            end else begin
                chk("frame_rev", a_r, q_rev.pop_front());
                chk("frame_nat", a_n, q_nat.pop_front());
            end
            snap_r = a_r;
            snap_n = a_n;
            exp_busy = S + 1;
        end else if (exp_busy > 0) begin
            chk("busy_rev", W'(busy_r), W'(1));
            chk("busy_nat", W'(busy_n), W'(1));
            chk("hold_rev", a_r, snap_r);
            chk("hold_nat", a_n, snap_n);
            exp_busy--;
        end else begin
            chk("idle_busy", W'({busy_r, busy_n}), W'(0));
        end
    end

    int unsigned rev_exp [D] = '{10, 14, 12, 16, 11, 15, 13, 17};
    int unsigned red_in  [4] = '{65536, 65537, 131071, 0};
    int unsigned red_exp [4] = '{65536, 0, 65534, 0};

    initial begin
        int starts0;
        int low;
        model_reset();
        #1;
        chk("rst_a_rev", a_r, '0);
        chk("rst_a_nat", a_n, '0);
        chk("rst_outs", W'({start_r, busy_r, start_n, busy_n}), W'(0));
        chk("rst_ready", W'({ready_r, ready_n}), W'(2'b11));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, N'(i));
        idle(6);
        for (int k = 0; k < D; k++) chk("natural_slot", W'(a_n[k*N +: N]), W'(k + 1));

        for (int i = 10; i <= 17; i++) cycle(1'b1, 1'b0, N'(i));
        idle(6);
        for (int k = 0; k < D; k++) chk("bitrev_slot", W'(a_r[k*N +: N]), W'(rev_exp[k]));

        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, N'(red_in[i]));
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, N'(i + 1));
        idle(6);
        for (int k = 0; k < 4; k++) chk("reduce_slot", W'(a_n[k*N +: N]), W'(red_exp[k]));

        starts0 = starts_seen;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, N'(100 + i));
        cycle(1'b1, 1'b1, N'(999));
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, N'(200 + i));
        idle(6);
        chk("flush_starts", W'(starts_seen - starts0), W'(1));
        for (int k = 0; k < D; k++) chk("flush_slot", W'(a_n[k*N +: N]), W'(200 + k));

        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, N'(300 + i));
        low = 0;
        for (int i = 0; i < 10; i++) begin
            if (ready_n) break;
            low++;
            cycle(1'b1, 1'b0, N'(555));
        end
        chk("backpressure_low", W'(low), W'(5));
        cycle(1'b1, 1'b0, N'(555));
        for (int i = 1; i < 8; i++) cycle(1'b1, 1'b0, N'(555 + i));
        idle(6);
        chk("held_slot0_nat", W'(a_n[N-1:0]), W'(555));
        chk("held_slot0_rev", W'(a_r[N-1:0]), W'(555));
        chk("held_slot1_nat", W'(a_n[2*N-1:N]), W'(556));

        starts0 = starts_seen;
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, N'(700 + i));
        idle(3);
        #2 rst = 1'b1;
        #1;
        chk("midrun_a_rev", a_r, '0);
        chk("midrun_a_nat", a_n, '0);
        chk("midrun_busy", W'({busy_r, busy_n, start_r, start_n}), W'(0));
        chk("midrun_ready", W'({ready_r, ready_n}), W'(2'b11));
        model_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        idle(6);
        chk("midrun_starts", W'(starts_seen - starts0), W'(1));

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                  N'($urandom_range(0, (1 << N) - 1)));
        idle(8);
        chk("queue_drained", W'(q_nat.size()), W'(0));
        chk("start_count", W'(starts_seen), W'(frames_pushed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
